rx_word_packer: RTL and testbench

RX_WORD_PACKER -- requirements
Module: rx_word_packer

---
 rtl/req_ack_pkg.sv | 8 +
 rtl/rx_word_packer.sv | 70 +++++++
 tb/tb_rx_word_packer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// req_ack_pkg: shared defaults and width helper for the receive word packer
package req_ack_pkg;
  localparam int DW_DEF = 16;
  localparam int PACK_DEF = 4;
  function automatic int cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction
endpackage

// File: rtl/rx_word_packer.sv
// rx_word_packer: packs PACK received words into one output beat, with flush of partial beats
module rx_word_packer
  import req_ack_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int PACK = PACK_DEF
) (
  input  logic                     clk_rx,
  input  logic                     rst_b,
  input  logic                     s_val,
  output logic                     s_rdy,
  input  logic [DW-1:0]            s_din,
  input  logic                     flush,
  output logic                     m_val,
  input  logic                     m_rdy,
  output logic [PACK*DW-1:0]       m_dout,
  output logic [cnt_w(PACK)-1:0]   m_cnt
);
  localparam int IW = $clog2(PACK);
  localparam int CW = cnt_w(PACK);
  localparam int BW = PACK * DW;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] acc_q, acc_d, dout_q, dout_d, merged;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_val_q, m_val_d, flush_pend_q, flush_pend_d;
  logic          out_free, last, accept, pend, emit;
  assign out_free = !m_val_q || m_rdy;
  assign last     = idx_q == IW'(PACK - 1);
  assign s_rdy    = !last || out_free;
  assign accept   = s_val && s_rdy;
  // a flush pulse acts on the same edge, so it is absorbed by any emission it coincides with
  assign pend     = flush_pend_q || flush;
  assign emit     = (accept && last) || (pend && out_free && (idx_q != '0 || accept));
  assign m_val    = m_val_q;
  assign m_dout   = dout_q;
  assign m_cnt    = cnt_q;
  // accumulator with the accepted word merged into its lane
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < PACK; k++)
      if (accept && idx_q == IW'(k)) merged[k*DW +: DW] = s_din;
  end
  // next-state: lane index, accumulator, pending flush and output register
  always_comb begin
    idx_d        = emit ? '0 : accept ? idx_q + 1'b1 : idx_q;
    acc_d        = emit ? '0 : merged;
    flush_pend_d = (emit || (pend && out_free && idx_q == '0 && !accept)) ? 1'b0 : pend;
    m_val_d      = emit || (m_val_q && !m_rdy);
    dout_d       = emit ? merged : dout_q;
    cnt_d        = emit ? CW'(idx_q) + CW'(accept) : cnt_q;
  end
  // state registers, asynchronously cleared
  always_ff @(posedge clk_rx or negedge rst_b) begin
    if (!rst_b) begin
      idx_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
      m_val_q      <= 1'b0;
      dout_q       <= '0;
      cnt_q        <= '0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
      m_val_q      <= m_val_d;
      dout_q       <= dout_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rx_word_packer.sv
// tb_rx_word_packer: scoreboard bench for rx_word_packer at DW=16, PACK=4
module tb_rx_word_packer;
  typedef struct {
    logic [63:0] d;
    logic [2:0]  c;
  } beat_t;
  logic        clk_rx = 0, rst_b = 0, s_val = 0, flush = 0, m_rdy = 0;
  logic        s_rdy, m_val;
  logic [15:0] s_din = '0;
  logic [63:0] m_dout;
  logic [2:0]  m_cnt;
  beat_t       q[$];
  int          n_vec = 0, n_err = 0;
  rx_word_packer #(.DW(16), .PACK(4)) dut (
    .clk_rx(clk_rx), .rst_b(rst_b), .s_val(s_val), .s_rdy(s_rdy), .s_din(s_din),
    .flush(flush), .m_val(m_val), .m_rdy(m_rdy), .m_dout(m_dout), .m_cnt(m_cnt)
  );
  always #5 clk_rx = ~clk_rx;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic monitor();
    beat_t b;
    forever begin
      @(negedge clk_rx);
      if (rst_b && m_val && m_rdy) begin
        if (q.size() == 0) chk("unexpected_beat", 64'(m_cnt), 64'd0);
        else begin
          b = q.pop_front();
          chk("beat_dout", m_dout, b.d);
          chk("beat_cnt", 64'(m_cnt), 64'(b.c));
        end
      end
    end
  endtask
  task automatic send(input logic [15:0] w, input logic f);
    int n = 0;
    s_val = 1; s_din = w; flush = f;
    @(negedge clk_rx);
    while (!s_rdy && n < 50) begin
      @(negedge clk_rx);
      n++;
    end
    if (!s_rdy) chk("accept_timeout", 64'(s_rdy), 64'd1);
    @(posedge clk_rx); #1;
    s_val = 0; flush = 0;
  endtask
  task automatic pulse_flush();
    flush = 1;
    @(posedge clk_rx); #1;
    flush = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk_rx);
    #1;
  endtask
  initial begin
    fork monitor(); join_none
    #2;
    chk("rst_m_val", 64'(m_val), 64'd0);
    chk("rst_m_cnt", 64'(m_cnt), 64'd0);
    chk("rst_m_dout", m_dout, 64'd0);
    chk("rst_s_rdy", 64'(s_rdy), 64'd1);
    idle(2);
    rst_b = 1;
    m_rdy = 1;
    idle(1);
    q.push_back('{64'h4444_3333_2222_1111, 3'd4});
    send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 0);
    chk("full_m_val", 64'(m_val), 64'd1);
    chk("full_m_dout", m_dout, 64'h4444_3333_2222_1111);
    idle(2);
    m_rdy = 0;
    q.push_back('{64'h0404_0303_0202_0101, 3'd4});
    q.push_back('{64'h0808_0707_0606_0505, 3'd4});
    send(16'h0101, 0); send(16'h0202, 0); send(16'h0303, 0); send(16'h0404, 0);
    send(16'h0505, 0); send(16'h0606, 0); send(16'h0707, 0);
    s_val = 1; s_din = 16'h0808;
    @(negedge clk_rx);
    chk("bp_s_rdy", 64'(s_rdy), 64'd0);
    chk("bp_idx", 64'(dut.idx_q), 64'd3);
    repeat (3) begin
      @(negedge clk_rx);
      chk("bp_hold_dout", m_dout, 64'h0404_0303_0202_0101);
      chk("bp_hold_cnt", 64'(m_cnt), 64'd4);
    end
    @(posedge clk_rx); #1;
    m_rdy = 1;
    @(posedge clk_rx); #1;
    s_val = 0;
    idle(2);
    q.push_back('{64'h0000_0000_BBBB_AAAA, 3'd2});
    send(16'hAAAA, 0); send(16'hBBBB, 0);
    pulse_flush();
    idle(2);
    q.push_back('{64'h0000_0000_0000_CCCC, 3'd1});
    send(16'hCCCC, 1);
    chk("sim_pend_absorbed", 64'(dut.flush_pend_q), 64'd0);
    idle(2);
    pulse_flush();
    @(negedge clk_rx);
    chk("idle_flush_pend", 64'(dut.flush_pend_q), 64'd0);
    chk("idle_flush_no_beat", 64'(m_val), 64'd0);
    idle(2);
    send(16'h0A0A, 0); send(16'h0B0B, 0);
    rst_b = 0;
    #1;
    chk("mid_rst_m_val", 64'(m_val), 64'd0);
    chk("mid_rst_idx", 64'(dut.idx_q), 64'd0);
    chk("mid_rst_s_rdy", 64'(s_rdy), 64'd1);
    idle(1);
    rst_b = 1;
    idle(1);
    q.push_back('{64'h8888_7777_6666_5555, 3'd4});
    send(16'h5555, 0);
    chk("post_rst_lane0", 64'(dut.acc_q[15:0]), 64'h5555);
    send(16'h6666, 0); send(16'h7777, 0); send(16'h8888, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk_rx);
    idle(1);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
